// File: rtl/tile_render_ctrl_pkg.sv
// Shared definitions for the tile renderer: FSM states, fixed colours and
// the bit layout of a board memory word {revealed, flagged, count[3:0]}.
package tile_render_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_SEND,
    ST_DONE
  } state_e;

  localparam logic [23:0] COLOR_HIDDEN = 24'hA6A6A6;
  localparam logic [23:0] COLOR_FLAG   = 24'hFF0000;

  localparam int RD_DATA_W       = 6;
  localparam int RD_REVEALED_BIT = 5;
  localparam int RD_FLAGGED_BIT  = 4;
  localparam int RD_COUNT_LSB    = 0;
  localparam int RD_COUNT_W      = 4;

endpackage

// File: rtl/tile_render_ctrl_if.sv
// Board-read and pixel-stream signals of the tile renderer.
// The master modport is the controller side; slave is the memory/sink side.
interface tile_render_ctrl_if #(
  parameter int ADDR_W = 6
);
  import tile_render_ctrl_pkg::*;

  logic                 start;
  logic                 busy;
  logic                 done;
  logic [ADDR_W-1:0]    rd_addr;
  logic                 rd_en;
  logic [RD_DATA_W-1:0] rd_data;
  logic                 pix_valid;
  logic                 pix_ready;
  logic [ADDR_W-1:0]    pix_addr;
  logic [23:0]          pix_color;

  modport master (
    input  start, rd_data, pix_ready,
    output busy, done, rd_addr, rd_en, pix_valid, pix_addr, pix_color
  );

  modport slave (
    output start, rd_data, pix_ready,
    input  busy, done, rd_addr, rd_en, pix_valid, pix_addr, pix_color
  );

endinterface

// File: rtl/tile_render_ctrl_color.sv
// Combinational mine-count to RGB888 lookup; counts above 8 render as the
// hidden-tile grey.
module tile_color
  import tile_render_ctrl_pkg::*;
(
  input  logic [3:0]  count,
  output logic [23:0] color
);

  always_comb begin
    case (count)
      4'd0:    color = 24'hFFFFFF;
      4'd1:    color = 24'hFF0000;
      4'd2:    color = 24'hFF6F00;
      4'd3:    color = 24'h2FFF00;
      4'd4:    color = 24'h00FFE1;
      4'd5:    color = 24'h00B3FF;
      4'd6:    color = 24'h9382C2;
      4'd7:    color = 24'hFF00EE;
      4'd8:    color = 24'hDEFF00;
      default: color = COLOR_HIDDEN;
    endcase
  end

endmodule

// File: rtl/tile_render_ctrl.sv
// Walks every board tile in ascending order, reads it, and streams its colour
// over a valid/ready port. Define TILE_RENDER_FLAG_EN to draw flagged hidden tiles red.
module tile_render_ctrl
  import tile_render_ctrl_pkg::*;
#(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int ADDR_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  tile_render_ctrl_if.master bus
);

`ifdef TILE_RENDER_FLAG_EN
  localparam bit FLAG_EN = 1'b1;
`else
  localparam bit FLAG_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ROWS * COLS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              pending_q, pending_d;
  logic [23:0]       color_q, color_d;
  logic [23:0]       count_color;
  logic [23:0]       tile_rgb;

  tile_color u_tile_color (
    .count (bus.rd_data[RD_COUNT_LSB +: RD_COUNT_W]),
    .color (count_color)
  );

  always_comb begin
    if (bus.rd_data[RD_REVEALED_BIT]) begin
      tile_rgb = count_color;
    end else if (FLAG_EN && bus.rd_data[RD_FLAGGED_BIT]) begin
      tile_rgb = COLOR_FLAG;
    end else begin
      tile_rgb = COLOR_HIDDEN;
    end
  end

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    color_d   = color_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_READ;
          idx_d   = '0;
        end
      end
      ST_READ: state_d = ST_WAIT;
      ST_WAIT: begin
        color_d = tile_rgb;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (bus.pix_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = ST_READ;
          end
        end
      end
      ST_DONE: begin
        // A start landing on the final cycle is treated like a queued one.
        pending_d = 1'b0;
        if (pending_q || bus.start) begin
          state_d = ST_READ;
          idx_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.start && (state_q inside {ST_READ, ST_WAIT, ST_SEND})) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      pending_q <= 1'b0;
      color_q   <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge value of its peers.
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      color_q   <= color_d;
    end
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.rd_en     = (state_q == ST_READ);
  assign bus.rd_addr   = idx_q;
  assign bus.pix_valid = (state_q == ST_SEND);
  assign bus.pix_addr  = idx_q;
  assign bus.pix_color = color_q;

endmodule

// File: tb/tb_tile_render_ctrl.sv
// Scoreboard bench for tile_render_ctrl: stimulus queues expected beats, a
// negedge monitor pops and compares each accepted pixel.
module tb_tile_render_ctrl;

`ifdef TILE_RENDER_FLAG_EN
  localparam bit FLAG_EN = 1'b1;
`else
  localparam bit FLAG_EN = 1'b0;
`endif

  typedef struct {
    logic [5:0]  addr;
    logic [23:0] color;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  tile_render_ctrl_if #(.ADDR_W(6)) bif ();

  tile_render_ctrl #(.ROWS(8), .COLS(8), .ADDR_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  logic [5:0] mem [0:63];
  logic [5:0] rd_data_q;
  always @(posedge clk) if (bif.rd_en) rd_data_q <= mem[bif.rd_addr];
  assign bif.rd_data = rd_data_q;

  beat_t exp_q [$];
  beat_t mon_beat;
  int    n_checks   = 0;
  int    n_pass     = 0;
  int    done_cnt   = 0;
  int    busy_drops = 0;
  bit    watch_busy = 1'b0;
  int    n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [23:0] exp_color(input logic [5:0] t);
    logic [23:0] c;
    if (t[5]) begin
      case (t[3:0])
        4'd0: c = 24'hFFFFFF;  4'd1: c = 24'hFF0000;  4'd2: c = 24'hFF6F00;
        4'd3: c = 24'h2FFF00;  4'd4: c = 24'h00FFE1;  4'd5: c = 24'h00B3FF;
        4'd6: c = 24'h9382C2;  4'd7: c = 24'hFF00EE;  4'd8: c = 24'hDEFF00;
        default: c = 24'hA6A6A6;
      endcase
    end else if (FLAG_EN && t[4]) begin
      c = 24'hFF0000;
    end else begin
      c = 24'hA6A6A6;
    end
    return c;
  endfunction

  task automatic load_board();
    for (int i = 0; i < 64; i++) mem[i] = {2'b10, 4'(i % 9)};
  endtask

  task automatic push_pass();
    beat_t b;
    for (int i = 0; i < 64; i++) begin
      b.addr  = 6'(i);
      b.color = exp_color(mem[i]);
      exp_q.push_back(b);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
  endtask

  task automatic wait_read(input logic [5:0] addr);
    int k = 0;
    do begin tick(); k++; end while (!(bif.rd_en && bif.rd_addr == addr) && k < 400);
    if (k >= 400) check("wait_read_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done();
    int k = 0;
    do begin tick(); k++; end while (!bif.done && k < 450);
    if (k >= 450) check("wait_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      32'(bif.busy),      32'd0);
    check({tag, "_done"},      32'(bif.done),      32'd0);
    check({tag, "_rd_en"},     32'(bif.rd_en),     32'd0);
    check({tag, "_pix_valid"}, 32'(bif.pix_valid), 32'd0);
    check({tag, "_rd_addr"},   32'(bif.rd_addr),   32'd0);
    check({tag, "_pix_addr"},  32'(bif.pix_addr),  32'd0);
    check({tag, "_pix_color"}, 32'(bif.pix_color), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bif.pix_valid && bif.pix_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(bif.pix_addr), 32'hFFFF_FFFF);
        end else begin
          mon_beat = exp_q.pop_front();
          check("beat_addr",  32'(bif.pix_addr),  32'(mon_beat.addr));
          check("beat_color", 32'(bif.pix_color), 32'(mon_beat.color));
        end
      end
      if (bif.done) done_cnt++;
      if (watch_busy && !bif.busy) busy_drops++;
    end
  end

  initial begin
    bif.start     = 1'b0;
    bif.pix_ready = 1'b0;
    load_board();

    #2 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Full pass, sink always ready: 64 in-order beats, 193 cycles start->done.
    bif.pix_ready = 1'b1;
    done_cnt = 0;
    push_pass();
    bif.start = 1'b1;
    n = 0;
    do begin tick(); bif.start = 1'b0; n++; end while (!bif.done && n < 400);
    check("start_to_done_cycles", 32'(n), 32'd193);
    tick();
    check("single_pass_done_cnt", 32'(done_cnt), 32'd1);
    check("single_pass_busy_low", 32'(bif.busy), 32'd0);
    check("single_pass_queue_empty", 32'(exp_q.size()), 32'd0);

    // Hidden/flagged tiles plus a 5-cycle stall on tile 10.
    mem[5] = 6'b01_0011;
    mem[6] = 6'b10_1100;
    check("tile5_model", 32'(exp_color(mem[5])), FLAG_EN ? 32'hFF0000 : 32'hA6A6A6);
    check("tile6_model", 32'(exp_color(mem[6])), 32'hA6A6A6);
    done_cnt = 0;
    push_pass();
    pulse_start();
    wait_read(6'd10);
    bif.pix_ready = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(bif.pix_valid), 32'd1);
      check("stall_addr",  32'(bif.pix_addr),  32'd10);
      check("stall_color", 32'(bif.pix_color), 32'hFF0000);
      check("stall_no_rd", 32'(bif.rd_en),     32'd0);
      tick();
    end
    bif.pix_ready = 1'b1;
    tick();
    check("after_stall_rd_en",   32'(bif.rd_en),   32'd1);
    check("after_stall_rd_addr", 32'(bif.rd_addr), 32'd11);
    wait_done();
    tick();
    check("stall_pass_done_cnt", 32'(done_cnt), 32'd1);
    check("stall_pass_queue_empty", 32'(exp_q.size()), 32'd0);

    // Two starts near tile 20: one queued, one dropped -> exactly two passes.
    load_board();
    done_cnt = 0;
    busy_drops = 0;
    push_pass();
    push_pass();
    pulse_start();
    watch_busy = 1'b1;
    wait_read(6'd20);
    pulse_start();
    pulse_start();
    wait_done();
    wait_done();
    tick();
    watch_busy = 1'b0;
    repeat (10) tick();
    check("two_pass_done_cnt", 32'(done_cnt), 32'd2);
    check("two_pass_busy_drops", 32'(busy_drops), 32'd0);
    check("two_pass_queue_empty", 32'(exp_q.size()), 32'd0);
    check("two_pass_idle", 32'(bif.busy), 32'd0);

    // A start in the DONE cycle chains straight into another pass.
    done_cnt = 0;
    busy_drops = 0;
    push_pass();
    push_pass();
    pulse_start();
    watch_busy = 1'b1;
    wait_done();
    pulse_start();
    check("chain_rd_en",   32'(bif.rd_en),   32'd1);
    check("chain_rd_addr", 32'(bif.rd_addr), 32'd0);
    wait_done();
    tick();
    watch_busy = 1'b0;
    check("chain_done_cnt", 32'(done_cnt), 32'd2);
    check("chain_busy_drops", 32'(busy_drops), 32'd0);
    check("chain_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset at tile 30 aborts; first start after release begins at tile 0.
    done_cnt = 0;
    push_pass();
    pulse_start();
    wait_read(6'd30);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    check("midreset_beats_left", 32'(exp_q.size()), 32'd34);
    exp_q.delete();
    repeat (3) tick();
    check("midreset_no_done", 32'(done_cnt), 32'd0);
    rst_n = 1'b1;
    push_pass();
    pulse_start();
    check("restart_rd_en",   32'(bif.rd_en),   32'd1);
    check("restart_rd_addr", 32'(bif.rd_addr), 32'd0);
    wait_done();
    tick();
    check("restart_done_cnt", 32'(done_cnt), 32'd1);
    check("restart_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tile_render_ctrl.md
TILE_RENDER_CTRL -- requirements
Module: tile_render_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 8: board rows.
REQ-002 SHALL have parameter COLS, default 8: board columns.
REQ-003 SHALL have parameter ADDR_W, default 6: tile address width; ROWS*COLS <= 2**ADDR_W.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: one-cycle request to redraw the whole board.
REQ-007 SHALL have port busy, output, 1: high while a redraw is in progress.
REQ-008 SHALL have port done, output, 1: one-cycle pulse when a redraw completes.
REQ-009 SHALL have port rd_addr, output, ADDR_W: board memory read address, row*COLS+col.
REQ-010 SHALL have port rd_en, output, 1: board read strobe.
REQ-011 SHALL have port rd_data, input, 6: {revealed, flagged, count[3:0]}, valid exactly 1 cycle after rd_en.
REQ-012 SHALL have port pix_valid, output, 1: tile colour output valid.
REQ-013 SHALL have port pix_ready, input, 1: sink accepts the tile colour.
REQ-014 SHALL have port pix_addr, output, ADDR_W: tile address of pix_color.
REQ-015 SHALL have port pix_color, output, 24: RGB888 tile colour.

Function
REQ-016 SHALL implement FSM states IDLE, READ, WAIT, SEND, DONE.
REQ-017 IDLE: on start, go to READ with tile index 0 and busy=1.
REQ-018 READ: assert rd_en for exactly one cycle with rd_addr equal to the current index, then go to WAIT.
REQ-019 WAIT: register rd_data, compute the colour, then go to SEND.
REQ-020 Colour rule: if revealed=1, pix_color SHALL be the count mapping 0=FFFFFF, 1=FF0000, 2=FF6F00, 3=2FFF00, 4=00FFE1, 5=00B3FF, 6=9382C2, 7=FF00EE, 8=DEFF00, otherwise A6A6A6.
REQ-021 Colour rule: if revealed=0, pix_color SHALL be A6A6A6, subject to REQ-033.
REQ-022 SEND: hold pix_valid, pix_addr and pix_color stable until pix_valid and pix_ready are high in the same cycle.
REQ-023 On a SEND handshake: if the index is ROWS*COLS-1, go to DONE; otherwise increment the index and go to READ.
REQ-024 DONE: pulse done=1 for one cycle, deassert busy, return to IDLE.
REQ-025 Throughput SHALL be a minimum of 3 cycles per tile; tile order SHALL be strictly ascending with no skips or repeats.
REQ-026 start while busy SHALL set a one-deep pending flag; further starts while it is set SHALL be dropped.
REQ-027 If pending is set in DONE, the FSM SHALL go to READ at index 0 instead of IDLE: done still pulses, busy stays high, and pending clears.
REQ-028 start in the same cycle as DONE SHALL count as pending (REQ-027 applies).
REQ-029 pix_ready high outside SEND SHALL have no effect.

Reset
REQ-030 While rst_n=0, outputs SHALL be: state IDLE, busy=0, done=0, rd_en=0, pix_valid=0, rd_addr=0, pix_addr=0, pix_color=0, pending=0, index=0.
REQ-031 Reset mid-redraw SHALL abort it immediately: no done pulse and no further pix_valid.
REQ-032 After rst_n deasserts, the first start SHALL be honoured in the first cycle.

Configuration
REQ-033 Macro TILE_RENDER_FLAG_EN: when defined, a tile with revealed=0 and flagged=1 SHALL render FF0000; when undefined, the flagged bit SHALL be ignored and the tile renders A6A6A6.

Structure
REQ-034 A shared package/include SHALL hold the FSM state encodings, the colour constants (HIDDEN A6A6A6, FLAG FF0000) and the rd_data field positions.
REQ-035 Count-to-colour mapping SHALL be one sub-module, tile_color (count[3:0] in, color[23:0] out, combinational), instantiated once.

Verification
REQ-036 Reset, single start, pix_ready tied 1, all tiles revealed with count=index%9 -> 64 beats in order 0..63, colours per REQ-020, done pulses once, total 193 cycles from start to done.
REQ-037 pix_ready held low for 5 cycles on tile 10 -> pix_addr=10 and pix_color held stable throughout, no rd_en during the stall, tile 11 follows.
REQ-038 Two starts at tile 20 of a redraw -> exactly two full passes, two done pulses, busy never drops between passes.
REQ-039 Tile 5 = {0,1,4'd3}: FLAG_EN defined -> FF0000; FLAG_EN undefined -> A6A6A6. Tile 6 = {1,0,4'd12} -> A6A6A6.
REQ-040 rst_n asserted at tile 30 -> all outputs 0 within the same cycle, no done pulse; a new start restarts at tile 0.
